// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and constants for the segment scan controller
// Purpose: scan FSM state encoding, blank digit code and decimal-point-off level.
// Ports: none (package).
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Any nibble 10..15 decodes to dark; 4'hF is the one the controller injects.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic DP_OFF = 1'b0;

endpackage

// File: rtl/segment.sv
// rtl/segment.sv - BCD code to seven-segment pattern lookup
// Purpose: combinational decode of one 4-bit code to an active-high pattern.
// Ports:
//   code    - 4-bit digit code, 0..9 shown, 10..15 dark
//   pattern - 8-bit segment pattern, bit 7 = dp (always off), bits 6:0 = g..a
module segment
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] pattern
);

    logic [6:0] seg7;

    always_comb begin
        seg7 = 7'h00;
        case (code)
            4'd0:    seg7 = 7'h3f;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5b;
            4'd3:    seg7 = 7'h4f;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6d;
            4'd6:    seg7 = 7'h7d;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7f;
            4'd9:    seg7 = 7'h6f;
            default: seg7 = 7'h00;
        endcase
    end

    assign pattern = {DP_OFF, seg7};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment display scan controller
// Purpose: time-multiplexes NUM_DIG BCD digits onto one segment bus with a
//          dead slot per digit, double-buffered loading, leading-zero
//          blanking and per-digit blinking.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   disp_data    - NUM_DIG BCD nibbles, nibble 0 is the rightmost digit
//   disp_valid   - disp_data offered; disp_ready - shadow buffer free
//   blank_lz     - leading-zero blanking enable
//   blink_mask   - per-digit blink enable
//   seg_led      - registered segment pattern, active-high
//   seg_sel      - registered digit enable, active-low
//   frame_done   - pulse in the last cycle of the last digit slot
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIG      = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   disp_data,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic                   blank_lz,
    input  logic [NUM_DIG-1:0]     blink_mask,
    output logic [7:0]             seg_led,
    output logic [NUM_DIG-1:0]     seg_sel,
    output logic                   frame_done
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIG);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    scan_state_t                state;
    scan_state_t                state_nxt;
    logic [PW-1:0]              pre;
    logic [IW-1:0]              idx;
    logic [BW-1:0]              blink_cnt;
    logic                       blink_phase;
    logic                       pending;
    logic [NUM_DIG-1:0][3:0]    active;
    logic [NUM_DIG-1:0][3:0]    shadow;

    logic                       slot_end;
    logic                       frame_end;
    logic                       load;
    logic [NUM_DIG-1:0]         lz_mask;
    logic                       zero_run;
    logic                       blank_now;
    logic [3:0]                 cur_code;
    logic [7:0]                 seg_pat;
    logic [NUM_DIG-1:0]         dig_onehot;
    logic [NUM_DIG-1:0]         sel_nxt;
    logic [7:0]                 led_nxt;

    assign slot_end   = (pre == PRE_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign frame_done = frame_end;
    assign disp_ready = ~pending;
    assign load       = disp_valid && ~pending;

    // lz_mask[k] is set when digit k and every digit above it are zero,
    // i.e. digit k is a leading zero (digit 0 is exempted below).
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            zero_run   = zero_run && (active[k] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    always_comb begin
        blank_now = (blank_lz && (idx != '0) && lz_mask[idx])
                 || (blink_phase && blink_mask[idx]);
        cur_code  = blank_now ? BLANK_CODE : active[idx];
    end

    segment u_segment (
        .code    (cur_code),
        .pattern (seg_pat)
    );

    assign dig_onehot = NUM_DIG'(1) << idx;

    // Output registers are loaded from the next-state view so that the
    // registered seg_sel/seg_led always match the FSM state they belong to.
    always_comb begin
        state_nxt = state;
        sel_nxt   = '1;
        led_nxt   = 8'h00;
        case (state)
            ST_DEAD: if (!slot_end) state_nxt = ST_SHOW;
            ST_SHOW: if (slot_end)  state_nxt = ST_DEAD;
            default: state_nxt = ST_DEAD;
        endcase
        if (state_nxt == ST_SHOW) begin
            sel_nxt = ~dig_onehot;
            led_nxt = seg_pat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_DEAD;
            seg_sel <= '1;
            seg_led <= 8'h00;
        end else begin
            state   <= state_nxt;
            seg_sel <= sel_nxt;
            seg_led <= led_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (slot_end) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Load into shadow needs pending clear; promotion needs pending set, so
    // the two can never collide. A load in the frame_done cycle waits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            active  <= {NUM_DIG{BLANK_CODE}};
            shadow  <= {NUM_DIG{BLANK_CODE}};
        end else if (load) begin
            shadow  <= disp_data;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per blink half-period, minimum 1.
REQ-004 Port clk, input, 1: single system clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port disp_data, input, 4*NUM_DIG: BCD digits; nibble k is digit k, digit 0 is rightmost.
REQ-007 Port disp_valid, input, 1: disp_data offered for load.
REQ-008 Port disp_ready, output, 1: controller can accept disp_data.
REQ-009 Port blank_lz, input, 1: leading-zero blanking enable, sampled every cycle.
REQ-010 Port blink_mask, input, NUM_DIG: per-digit blink enable, sampled every cycle.
REQ-011 Port seg_led, output, 8: segment pattern, active-high, bit 7 = dp, always 0.
REQ-012 Port seg_sel, output, NUM_DIG: digit enable, active-low, at most one bit low.
REQ-013 Port frame_done, output, 1: one-cycle pulse when the last digit slot of a frame ends.

Function
REQ-014 Prescaler counts 0..DIV-1 and wraps; the wrap cycle ends the current digit slot.
REQ-015 Digit index advances 0,1,..,NUM_DIG-1,0 at each slot end; one frame = NUM_DIG*DIV cycles.
REQ-016 FSM states: DEAD (first cycle of each slot) and SHOW (remaining DIV-1 cycles).
REQ-017 DEAD: seg_sel all ones, seg_led 8'h00 (ghosting guard); slot end always returns to DEAD.
REQ-018 SHOW: seg_sel bit of current index low, all others high; seg_led = pattern of that digit.
REQ-019 seg_sel and seg_led are registered and change on the same edge; no combinational path from any input to them.
REQ-020 Digit patterns: 0..9 = 3f,06,5b,4f,66,6d,7d,07,7f,6f; any nibble 10..15 displays as 8'h00.
REQ-021 Two buffers: shadow (loaded by handshake) and active (displayed); pending flag marks shadow full.
REQ-022 disp_ready = not pending; transfer occurs on disp_valid && disp_ready; pending then sets.
REQ-023 At frame end (frame_done cycle) with pending set: shadow copies to active, pending clears, disp_ready rises next cycle.
REQ-024 A transfer in the frame_done cycle lands in shadow and displays after the following frame end; active never changes mid-frame.
REQ-025 disp_valid while disp_ready is low is ignored; the source holds data until disp_ready.
REQ-026 blank_lz=1: digits above the highest nonzero active digit show 8'h00; digit 0 always shown; all-zero shows a single 0.
REQ-027 Blink phase toggles every BLINK_FRAMES frames; when phase=1, digits with blink_mask bit set show 8'h00.
REQ-028 Blanking rules (REQ-020, 026, 027) combine by OR; seg_sel still scans blanked digits.

Reset
REQ-029 rst at any cycle, including mid-slot or mid-handshake, takes effect on the next edge and dominates all other inputs.
REQ-030 Reset values: seg_sel all ones, seg_led 8'h00, frame_done 0, disp_ready 1, pending 0, prescaler 0, digit index 0, FSM DEAD, blink phase 0, frame counter 0.
REQ-031 Reset fills active and shadow buffers with nibble 4'hF, displaying blank until the first load.

Structure
REQ-032 Shared package holds the FSM state encoding (DEAD, SHOW), the blank code 4'hF and the dp-off constant.
REQ-033 Pattern lookup is a sub-module, segment (4-bit code in, 8-bit pattern out), instantiated once; the controller passes code 4'hF to blank.
REQ-034 Prescaler, digit index, blink counter, handshake and blanking logic live in seg_scan_ctrl; target 120-400 RTL lines.

Verification (NUM_DIG=4, DIV=4, BLINK_FRAMES=2)
REQ-035 Reset, load 16'h1234, wait one frame end -> digit0 slot SHOW: seg_sel 1110, seg_led 66; digit3 slot: seg_sel 0111, seg_led 06; each DEAD cycle shows 1111/00.
REQ-036 blank_lz=1, load 16'h0070 -> digits 3,2 seg_led 00; digit1 07; digit0 3f; 16'h0000 -> only digit0 shows 3f.
REQ-037 Load A, then hold disp_valid with B -> disp_ready low until first frame_done, A displays next frame, B accepted the cycle after, shown one frame later.
REQ-038 Load 16'hA5F9 -> digit3 00, digit2 6d, digit1 00, digit0 6f.
REQ-039 blink_mask 0001 on 16'h1111 -> digit0 shows 06 in frames 0-1, 00 in frames 2-3, 06 in 4-5; other digits always 06.
REQ-040 Assert rst for one cycle mid-SHOW with pending set -> next cycle seg_sel 1111, seg_led 00, disp_ready 1, frame_done 0; display blank until a new load and frame end.
